// File: rtl/mem_arbiter_if.sv
// Core-side and memory-side buses of the fetch/data memory arbiter.
// The core side carries both requester ports plus grant/err status; the memory side is a level req/ack port.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              err;
  logic [1:0]        grant;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_rdata, i_ready, d_rdata, d_ready, err, grant
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_rdata, i_ready, d_rdata, d_ready, err, grant
  );
endinterface

interface mem_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_rdata, m_ack
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_rdata, m_ack
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory between fetch and data ports; m_req follows the
// sampling edge, ready/err pulse the cycle after m_ack or timeout; requesters hold req until their ready pulse.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave core,
  mem_port_if.master   mem
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY_I,
    S_BUSY_D,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;

  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              err_q, err_d;
  logic [1:0]        grant_q, grant_d;

  logic              pick_fetch;
  logic              busy_done;
  logic              timed_out;

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign timed_out = (cnt_inc == CNT_W'(TIMEOUT));
  assign busy_done = mem.m_ack || timed_out;

  // On a tie the side that did not own the memory last time wins.
  assign pick_fetch = core.i_req && (!core.d_req || last_d_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      last_d_q  <= 1'b0;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      err_q     <= 1'b0;
      grant_q   <= GNT_NONE;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      err_q     <= err_d;
      grant_q   <= grant_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    err_d     = 1'b0;
    grant_d   = grant_q;

    case (state_q)
      S_IDLE: begin
        if (pick_fetch) begin
          state_d   = S_BUSY_I;
          last_d_d  = 1'b0;
          cnt_d     = '0;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = core.i_addr;
          m_wdata_d = '0;
          grant_d   = GNT_I;
        end else if (core.d_req) begin
          state_d   = S_BUSY_D;
          last_d_d  = 1'b1;
          cnt_d     = '0;
          m_req_d   = 1'b1;
          m_we_d    = core.d_we;
          m_addr_d  = core.d_addr;
          m_wdata_d = core.d_wdata;
          grant_d   = GNT_D;
        end
      end

      S_BUSY_I: begin
        if (busy_done) begin
          state_d   = S_RESP;
          m_req_d   = 1'b0;
          i_ready_d = 1'b1;
          err_d     = !mem.m_ack;
          i_rdata_d = mem.m_ack ? mem.m_rdata : '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_BUSY_D: begin
        if (busy_done) begin
          state_d   = S_RESP;
          m_req_d   = 1'b0;
          d_ready_d = 1'b1;
          err_d     = !mem.m_ack;
          // Writes return zero so stale read data never looks fresh.
          d_rdata_d = (mem.m_ack && !m_we_q) ? mem.m_rdata : '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        grant_d = GNT_NONE;
      end

      default: begin
        state_d = S_IDLE;
        m_req_d = 1'b0;
        grant_d = GNT_NONE;
      end
    endcase
  end

  assign mem.m_req   = m_req_q;
  assign mem.m_we    = m_we_q;
  assign mem.m_addr  = m_addr_q;
  assign mem.m_wdata = m_wdata_q;

  assign core.i_rdata = i_rdata_q;
  assign core.i_ready = i_ready_q;
  assign core.d_rdata = d_rdata_q;
  assign core.d_ready = d_ready_q;
  assign core.err     = err_q;
  assign core.grant   = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand sequences for reset, timeout and starvation.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cif ();
  mem_port_if    #(.ADDR_W(32), .DATA_W(32)) mif ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cif2 ();
  mem_port_if    #(.ADDR_W(32), .DATA_W(32)) mif2 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .core(cif), .mem(mif)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .core(cif2), .mem(mif2)
  );

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        ak;
    logic [31:0] rd;
    logic        e_mreq;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [1:0]  e_grant;
    logic        e_irdy;
    logic        e_drdy;
    logic        e_err;
    logic [31:0] e_irdata;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] IA = 32'h200, DA = 32'h300;
  localparam logic [31:0] F0 = 32'h8C010004, WD = 32'hDEADBEEF, RD = 32'h12345678;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] dwd, input logic ak, input logic [31:0] rd,
                     input logic emr, input logic emw, input logic [31:0] ema, input logic [31:0] emwd,
                     input logic [1:0] eg, input logic eir, input logic edr, input logic eer,
                     input logic [31:0] eird, input logic [31:0] edrd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.ak = ak; v.rd = rd;
    v.e_mreq = emr; v.e_mwe = emw; v.e_maddr = ema; v.e_mwdata = emwd; v.e_grant = eg;
    v.e_irdy = eir; v.e_drdy = edr; v.e_err = eer; v.e_irdata = eird; v.e_drdata = edrd;
    vecs.push_back(v);
  endtask

  task automatic finish_bench();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, fetch_arb, n_arb, n_d;
    logic seen, got_err, i_raised;
    logic [31:0] got_rdata;
    logic [1:0]  prev_g;

    reset = 1'b0;
    cif.i_req = 0; cif.i_addr = 0; cif.d_req = 0; cif.d_we = 0; cif.d_addr = 0; cif.d_wdata = 0;
    cif2.i_req = 0; cif2.i_addr = 0; cif2.d_req = 0; cif2.d_we = 0; cif2.d_addr = 0; cif2.d_wdata = 0;
    mif.m_ack = 0; mif.m_rdata = 0; mif2.m_ack = 0; mif2.m_rdata = 0;

    // Tie rotation (data wins first), both requests held, memory acks immediately.
    add(1, IA, 1, 0, DA, 0, 1, 0,              0, 0, 0,  0, 2'b00, 0, 0, 0, 0, 0);
    add(1, IA, 1, 0, DA, 0, 1, 32'hA1,         1, 0, DA, 0, 2'b10, 0, 0, 0, 0, 0);
    add(1, IA, 1, 0, DA, 0, 1, 0,              0, 0, 0,  0, 2'b10, 0, 1, 0, 0, 32'hA1);
    add(1, IA, 1, 0, DA, 0, 1, 0,              0, 0, 0,  0, 2'b00, 0, 0, 0, 0, 32'hA1);
    add(1, IA, 1, 0, DA, 0, 1, 32'hB2,         1, 0, IA, 0, 2'b01, 0, 0, 0, 0, 32'hA1);
    add(1, IA, 1, 0, DA, 0, 1, 0,              0, 0, 0,  0, 2'b01, 1, 0, 0, 32'hB2, 32'hA1);
    add(1, IA, 1, 0, DA, 0, 1, 0,              0, 0, 0,  0, 2'b00, 0, 0, 0, 32'hB2, 32'hA1);
    add(1, IA, 1, 0, DA, 0, 1, 32'hC3,         1, 0, DA, 0, 2'b10, 0, 0, 0, 32'hB2, 32'hA1);
    add(1, IA, 1, 0, DA, 0, 1, 0,              0, 0, 0,  0, 2'b10, 0, 1, 0, 32'hB2, 32'hC3);
    add(1, IA, 1, 0, DA, 0, 1, 0,              0, 0, 0,  0, 2'b00, 0, 0, 0, 32'hB2, 32'hC3);
    add(1, IA, 1, 0, DA, 0, 1, 32'hD4,         1, 0, IA, 0, 2'b01, 0, 0, 0, 32'hB2, 32'hC3);
    add(0, 0,  0, 0, 0,  0, 0, 0,              0, 0, 0,  0, 2'b01, 1, 0, 0, 32'hD4, 32'hC3);
    // Single fetch at 0x100, ack one cycle after m_req.
    add(1, 32'h100, 0, 0, 0, 0, 0, 0,          0, 0, 0,  0, 2'b00, 0, 0, 0, 32'hD4, 32'hC3);
    add(1, 32'h100, 0, 0, 0, 0, 1, F0,         1, 0, 32'h100, 0, 2'b01, 0, 0, 0, 32'hD4, 32'hC3);
    add(0, 0, 0, 0, 0, 0, 0, 0,                0, 0, 0,  0, 2'b01, 1, 0, 0, F0, 32'hC3);
    // Data write with a 5-cycle memory; rdata on the ack cycle must not leak into d_rdata.
    add(0, 0, 1, 1, 32'h40, WD, 0, 0,          0, 0, 0,  0, 2'b00, 0, 0, 0, F0, 32'hC3);
    for (int k = 0; k < 4; k++)
      add(0, 0, 1, 1, 32'h40, WD, 0, 32'hFFFF0000, 1, 1, 32'h40, WD, 2'b10, 0, 0, 0, F0, 32'hC3);
    add(0, 0, 1, 1, 32'h40, WD, 1, 32'h77777777, 1, 1, 32'h40, WD, 2'b10, 0, 0, 0, F0, 32'hC3);
    add(0, 0, 0, 0, 0, 0, 0, 0,                0, 0, 0,  0, 2'b10, 0, 1, 0, F0, 0);
    // Data read at 0x44.
    add(0, 0, 1, 0, 32'h44, 0, 0, 0,           0, 0, 0,  0, 2'b00, 0, 0, 0, F0, 0);
    add(0, 0, 1, 0, 32'h44, 0, 1, RD,          1, 0, 32'h44, 0, 2'b10, 0, 0, 0, F0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,                0, 0, 0,  0, 2'b10, 0, 1, 0, F0, RD);
    add(0, 0, 0, 0, 0, 0, 0, 0,                0, 0, 0,  0, 2'b00, 0, 0, 0, F0, RD);

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset m_req", mif.m_req, 0);      chk("reset m_we", mif.m_we, 0);
    chk("reset m_addr", mif.m_addr, 0);    chk("reset m_wdata", mif.m_wdata, 0);
    chk("reset i_ready", cif.i_ready, 0);  chk("reset d_ready", cif.d_ready, 0);
    chk("reset err", cif.err, 0);          chk("reset i_rdata", cif.i_rdata, 0);
    chk("reset d_rdata", cif.d_rdata, 0);  chk("reset grant", cif.grant, 0);
    chk("reset2 m_req", mif2.m_req, 0);    chk("reset2 grant", cif2.grant, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < vecs.size(); r++) begin
      vec_t v;
      v = vecs[r];
      cif.i_req = v.ir; cif.i_addr = v.ia; cif.d_req = v.dr; cif.d_we = v.dw;
      cif.d_addr = v.da; cif.d_wdata = v.dwd; mif.m_ack = v.ak; mif.m_rdata = v.rd;
      @(negedge clk);
      chk($sformatf("row%0d m_req", r), mif.m_req, v.e_mreq);
      if (v.e_mreq) begin
        chk($sformatf("row%0d m_we", r), mif.m_we, v.e_mwe);
        chk($sformatf("row%0d m_addr", r), mif.m_addr, v.e_maddr);
        chk($sformatf("row%0d m_wdata", r), mif.m_wdata, v.e_mwdata);
      end
      chk($sformatf("row%0d grant", r), cif.grant, v.e_grant);
      chk($sformatf("row%0d i_ready", r), cif.i_ready, v.e_irdy);
      chk($sformatf("row%0d d_ready", r), cif.d_ready, v.e_drdy);
      chk($sformatf("row%0d err", r), cif.err, v.e_err);
      chk($sformatf("row%0d i_rdata", r), cif.i_rdata, v.e_irdata);
      chk($sformatf("row%0d d_rdata", r), cif.d_rdata, v.e_drdata);
      @(posedge clk); #1;
    end

    // Starvation: data hammers the memory; fetch must win within two arbitrations of rising.
    cif.d_req = 1; cif.d_we = 0; cif.d_addr = 32'h500; mif.m_ack = 1; mif.m_rdata = 32'h1;
    i_raised = 0; n_d = 0; n_arb = 0; fetch_arb = 0; prev_g = 2'b00;
    for (int c = 0; c < 200 && !(n_d >= 10 && fetch_arb != 0); c++) begin
      @(negedge clk);
      if (cif.grant != 2'b00 && prev_g == 2'b00 && i_raised) begin
        n_arb++;
        if (cif.grant == 2'b01 && fetch_arb == 0) fetch_arb = n_arb;
      end
      prev_g = cif.grant;
      if (cif.d_ready) n_d++;
      if (cif.i_ready) cif.i_req = 0;
      if (n_d == 3 && !i_raised) begin
        cif.i_req = 1; cif.i_addr = 32'h600; i_raised = 1;
      end
    end
    cif.d_req = 0; cif.i_req = 0; mif.m_ack = 0;
    chk("starve data_accesses", (n_d >= 10), 1);
    chk("starve fetch_within_2", (fetch_arb >= 1 && fetch_arb <= 2), 1);
    repeat (2) @(posedge clk);

    // Asynchronous reset in the middle of a data access.
    @(posedge clk); #1;
    cif.d_req = 1; cif.d_we = 1; cif.d_addr = 32'h88; cif.d_wdata = 32'h1234;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst pre m_req", mif.m_req, 1);
    chk("midrst pre grant", cif.grant, 2'b10);
    #2 reset = 1'b0;
    #1;
    chk("midrst m_req", mif.m_req, 0);
    chk("midrst grant", cif.grant, 0);
    chk("midrst m_addr", mif.m_addr, 0);
    cif.d_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (cif.d_ready || mif.m_req || cif.err || cif.grant != 0) seen = 1;
    end
    chk("midrst quiet after release", seen, 0);

    // Timeout instance: successful read first so a zeroed d_rdata is visible.
    @(posedge clk); #1;
    cif2.d_req = 1; cif2.d_we = 0; cif2.d_addr = 32'h80; mif2.m_ack = 0;
    @(posedge clk); #1;
    mif2.m_ack = 1; mif2.m_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    mif2.m_ack = 0; cif2.d_req = 0;
    @(negedge clk);
    chk("to pre d_ready", cif2.d_ready, 1);
    chk("to pre d_rdata", cif2.d_rdata, 32'h55AA55AA);
    chk("to pre err", cif2.err, 0);
    @(posedge clk); #1;
    cif2.d_req = 1; cif2.d_addr = 32'h84;
    busy_cnt = 0; seen = 0; got_err = 0; got_rdata = 32'hX;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (cif2.d_ready) begin
        seen = 1; got_err = cif2.err; got_rdata = cif2.d_rdata;
      end else if (mif2.m_req) begin
        busy_cnt++;
      end
    end
    chk("to ready seen", seen, 1);
    chk("to busy cycles", busy_cnt, 4);
    chk("to err", got_err, 1);
    chk("to d_rdata", got_rdata, 0);
    chk("to m_req dropped", mif2.m_req, 0);
    cif2.d_req = 0; mif2.m_ack = 1; mif2.m_rdata = 32'h99999999;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (cif2.d_ready || cif2.err || mif2.m_req || cif2.d_rdata != 0) seen = 1;
    end
    chk("to late ack ignored", seen, 0);
    mif2.m_ack = 0;

    finish_bench();
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one single-ported, variable-latency backing memory between the pipelined core's instruction-fetch port and its data port. Sits between the core (fetch address/instruction, data address/write data/read data, ready handshakes) and the memory. Serialises accesses through a request/acknowledge FSM and aborts any access whose acknowledge exceeds a timeout, reporting an error.

## Interface
- ADDR_W, 32, address width, both sides
- DATA_W, 32, data width
- TIMEOUT, 64, max cycles in BUSY waiting for m_ack (≥2); counter width $clog2(TIMEOUT+1)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- i_req  in  1  fetch request; held with i_addr stable until i_ready
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word, valid when i_ready
- i_ready  out  1  one-cycle completion pulse, fetch side
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data, valid when d_ready and !d_we
- d_ready  out  1  one-cycle completion pulse, data side
- err  out  1  pulses with i_ready/d_ready when the access timed out
- m_req  out  1  memory request, level, held until m_ack or timeout
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid with m_ack
- m_ack  in  1  memory completion, sampled on clk
- grant  out  2  owner: 00 none, 01 fetch, 10 data

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: if exactly one req high, grant it. Both high: grant the side not granted last (last_grant register; reset value = fetch, so data wins the first tie). Neither: stay.
- Entering BUSY_x: register m_req=1, m_we (d_we for data, 0 for fetch), m_addr, m_wdata (0 for fetch), grant; clear timeout counter; update last_grant.
- BUSY_x: m_req and memory-side outputs held constant. Counter increments every cycle without m_ack.
- m_ack sampled high in BUSY_x → RESP: m_req=0, x_rdata<=m_rdata (data writes: d_rdata<=0), x_ready=1, err=0.
- Counter reaches TIMEOUT without m_ack → RESP: m_req=0, x_rdata<=0, x_ready=1, err=1. A late m_ack arriving in RESP/IDLE is ignored.
- RESP → IDLE unconditionally (one cycle). This gives the requester time to drop or renew req before the next arbitration.
- m_ack while not in BUSY: ignored.
- i_rdata/d_rdata hold their last value until overwritten. Only the owning side's ready pulses.

## Timing
- Reset (reset low, asynchronous): state=IDLE, last_grant=fetch, counter=0. All outputs 0: m_req, m_we, m_addr, m_wdata, i_ready, d_ready, err, i_rdata, d_rdata, grant. Reset mid-access drops m_req immediately and produces no ready pulse.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: req sampled in IDLE at edge E → m_req high after E. m_ack sampled at edge E+k (k≥1) → ready high for the cycle after E+k. With k=1, ready is 2 cycles after the req-sampling edge.
- Back-to-back throughput: IDLE→BUSY→RESP→IDLE gives a minimum of 3 cycles per access.
- Timeout: with no ack, ready+err pulse in the cycle after the TIMEOUT-th BUSY cycle.
- Ready and err are single-cycle pulses and never assert in IDLE or BUSY.

## Test plan
- Reset: drive reset low mid-BUSY_D → m_req=0, grant=00 asynchronously; outputs stay 0 after release; no d_ready pulse.
- Single fetch: i_req, i_addr=0x100; memory acks 1 cycle after m_req with m_rdata=0x8C010004 → m_we=0, m_addr=0x100; i_ready one cycle later with i_rdata=0x8C010004; d_ready stays 0.
- Data write with 5-cycle memory: d_req, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF → m_* held stable for 5 cycles; d_ready pulses once; err=0.
- Tie rotation: i_req and d_req both high continuously, memory acks immediately → grant sequence data, fetch, data, fetch; 3 cycles per access.
- Timeout (TIMEOUT=4): d_req read, m_ack never asserts → m_req drops after 4 BUSY cycles; d_ready=1 with err=1 and d_rdata=0; a late m_ack is ignored.
- Starvation check: d_req held high for 10 accesses while i_req is asserted → fetch is granted no later than the second arbitration after i_req rises.
